irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller that schedules the fetch stage's PC-override path (interrupt_en / interrupt_handling_addr).
- Latches edge-triggered requests, arbitrates by fixed priority and injects the handler vector into fetch only in cycles where the PC register actually loads.
- Saves the return PC, then re-steers fetch to it on mret through the same override path.
- Sits beside fetch; configured by a small register port from the core.

Parameters:
NUM_IRQ, 4, number of interrupt sources (1..8)
VEC_BASE, 32'h0000_0100, handler address of source 0
VEC_STRIDE, 32'h0000_0010, byte spacing between consecutive handler vectors

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
irq_in  input  NUM_IRQ  request lines, synchronous to clk, rising-edge sensitive
fetch_pc  input  32  current fetch PC
stall  input  1  fetch stall (PC holds when high)
pc_next_sel  input  1  branch/jump redirect active this cycle
mret  input  1  one-cycle pulse: return-from-interrupt decoded
cfg_we  input  1  config write strobe
cfg_addr  input  2  config register select
cfg_wdata  input  32  config write data
cfg_rdata  output  32  config read data (combinational on cfg_addr)
interrupt_en  output  1  PC override request to fetch
interrupt_handling_addr  output  32  override target PC
irq_id  output  3  source currently being served
in_isr  output  1  high from handler entry until the return override is accepted

Behaviour:
- Reset: state IDLE; pending, mask, gie, epc, interrupt_handling_addr, irq_id and in_isr all 0. interrupt_en is 0 while in reset. rst asserted mid-operation aborts any take or return immediately.
- Edge detect: prev_irq register. A rising edge on bit i sets pending[i]. If a set and a clear hit the same bit in the same cycle, the set wins.
- Config registers:
  - addr0 = mask[NUM_IRQ-1:0], read/write.
  - addr1 = gie in bit 0, read/write.
  - addr2 = pending; write-1-to-clear; reads pending.
  - addr3 = epc, read-only; writes are ignored.
  - Unused read bits return 0.
- Arbitration: eligible = pending & mask when gie=1. The lowest index wins.
- States:
  - IDLE: if eligible != 0, load irq_id = winner and interrupt_handling_addr = VEC_BASE + winner*VEC_STRIDE (mod 2^32), clear pending[winner], go to TAKE.
  - TAKE: interrupt_en = !stall && !pc_next_sel (combinational). On an accepted cycle (interrupt_en=1): epc <= fetch_pc + 4, in_isr <= 1, go to ISR. A blocked cycle holds TAKE with no timeout. Mask or gie changes after entry to TAKE do not cancel the take.
  - ISR: no new takes, but pending keeps accumulating. On mret: interrupt_handling_addr <= epc, go to RET.
  - RET: interrupt_en = !stall && !pc_next_sel. On accept: in_isr <= 0, go to IDLE. A new take may start the following cycle.
- interrupt_en is 0 in IDLE and ISR. mret outside ISR is ignored.
- Latency with no stalls: irq edge sampled at edge N, pending set; IDLE→TAKE at edge N+1; interrupt_en high in cycle N+1 to N+2; fetch PC equals the vector after edge N+2.

Test Plan:
- Reset, mask=4'hF, gie=1, pulse irq_in[2] with fetch_pc=0x40 → interrupt_en high one cycle two cycles later, addr 0x120, irq_id=2, epc=0x44, in_isr=1.
- irq_in[1] and irq_in[3] rising together → source 1 is served first (addr 0x110); after mret accept, source 3 is served (addr 0x130), pending ends at 0.
- TAKE entered while stall=1 for 3 cycles, then pc_next_sel=1 for 1 cycle → interrupt_en stays 0 for those 4 cycles, asserts on the first clean cycle, and epc captures fetch_pc+4 of that cycle.
- In ISR, pulse irq_in[0] → no take and pending[0]=1; mret → override to epc, then vector 0x100 is taken after return.
- gie=0 with pending set → no take; write addr2=1<<i → pending[i] cleared; a rising edge on the same bit in the same cycle as the clear leaves pending[i]=1.
- Assert rst while in TAKE → interrupt_en drops immediately; all registers read 0 after reset.

Source files
------------

// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller: fixed-priority take, handler vectoring and
// mret return, both steered into fetch through the PC-override path.
module irq_ctrl #(
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [31:0]        fetch_pc,
  input  logic               stall,
  input  logic               pc_next_sel,
  input  logic               mret,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               interrupt_en,
  output logic [31:0]        interrupt_handling_addr,
  output logic [2:0]         irq_id,
  output logic               in_isr
);

  typedef enum logic [1:0] {S_IDLE, S_TAKE, S_ISR, S_RET} state_t;

  state_t             state_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] prev_irq_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic               gie_q;
  logic [31:0]        epc_q;
  logic [31:0]        addr_q;
  logic [2:0]         irq_id_q;
  logic               in_isr_q;

  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] take_clr;
  logic [NUM_IRQ-1:0] cfg_clr;
  logic [2:0]         win_idx;
  logic               take;
  logic [31:0]        vec_addr;
  logic               unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:NUM_IRQ];

  // Lowest index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    eligible = gie_q ? (pending_q & mask_q) : '0;
    win_idx  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = 3'(i);
    end
    take     = (state_q == S_IDLE) && (|eligible);
    vec_addr = VEC_BASE + 32'(win_idx) * VEC_STRIDE;
  end

  // A new rising edge beats any clear landing on the same bit.
  always_comb begin
    take_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      take_clr[i] = take && (win_idx == 3'(i));
    end
    cfg_clr   = (cfg_we && (cfg_addr == 2'd2)) ? cfg_wdata[NUM_IRQ-1:0] : '0;
    pending_d = (pending_q & ~(take_clr | cfg_clr)) | (irq_in & ~prev_irq_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      prev_irq_q <= '0;
      mask_q     <= '0;
      gie_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      prev_irq_q <= irq_in;
      if (cfg_we && (cfg_addr == 2'd0)) mask_q <= cfg_wdata[NUM_IRQ-1:0];
      if (cfg_we && (cfg_addr == 2'd1)) gie_q  <= cfg_wdata[0];
    end
  end

  assign interrupt_en = ((state_q == S_TAKE) || (state_q == S_RET)) && !stall && !pc_next_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      epc_q    <= '0;
      addr_q   <= '0;
      irq_id_q <= '0;
      in_isr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (take) begin
          irq_id_q <= win_idx;
          addr_q   <= vec_addr;
          state_q  <= S_TAKE;
        end
        S_TAKE: if (interrupt_en) begin
          epc_q    <= fetch_pc + 32'd4;
          in_isr_q <= 1'b1;
          state_q  <= S_ISR;
        end
        S_ISR: if (mret) begin
          addr_q  <= epc_q;
          state_q <= S_RET;
        end
        S_RET: if (interrupt_en) begin
          in_isr_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0:    cfg_rdata[NUM_IRQ-1:0] = mask_q;
      2'd1:    cfg_rdata[0]           = gie_q;
      2'd2:    cfg_rdata[NUM_IRQ-1:0] = pending_q;
      default: cfg_rdata              = epc_q;
    endcase
  end

  assign interrupt_handling_addr = addr_q;
  assign irq_id                  = irq_id_q;
  assign in_isr                  = in_isr_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: a transaction-level model predicts every cycle's
// outputs, a negedge monitor pops and compares; directed scenarios then random traffic.
module tb_irq_ctrl;
  localparam int          NUM = 4;
  localparam logic [31:0] VB  = 32'h0000_0100;
  localparam logic [31:0] VS  = 32'h0000_0010;
  localparam int PH_WAIT = 0, PH_TAKING = 1, PH_HANDLER = 2, PH_RETURNING = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NUM-1:0] irq_in = '0;
  logic [31:0]    fetch_pc = '0;
  logic           stall = 1'b0, pc_next_sel = 1'b0, mret = 1'b0, cfg_we = 1'b0;
  logic [1:0]     cfg_addr = '0;
  logic [31:0]    cfg_wdata = '0;
  logic [31:0]    cfg_rdata;
  logic           interrupt_en;
  logic [31:0]    interrupt_handling_addr;
  logic [2:0]     irq_id;
  logic           in_isr;

  irq_ctrl #(.NUM_IRQ(NUM), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .fetch_pc(fetch_pc), .stall(stall),
    .pc_next_sel(pc_next_sel), .mret(mret), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .interrupt_en(interrupt_en),
    .interrupt_handling_addr(interrupt_handling_addr), .irq_id(irq_id), .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic [2:0]  id;
    logic        isr;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: source-level bookkeeping of what software and fetch should see.
  bit          m_pend[NUM], m_mask[NUM], m_prev[NUM];
  bit          m_gie, m_isr;
  int          m_phase, m_id;
  logic [31:0] m_epc, m_addr;

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin
      m_pend[i] = 0; m_mask[i] = 0; m_prev[i] = 0;
    end
    m_gie = 0; m_isr = 0; m_phase = PH_WAIT; m_id = 0; m_epc = 0; m_addr = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] v = 0;
    case (a)
      2'd0: for (int i = 0; i < NUM; i++) if (m_mask[i]) v += 32'(1) << i;
      2'd1: v = m_gie ? 32'd1 : 32'd0;
      2'd2: for (int i = 0; i < NUM; i++) if (m_pend[i]) v += 32'(1) << i;
      default: v = m_epc;
    endcase
    return v;
  endfunction

  function automatic bit m_override();
    return (m_phase == PH_TAKING || m_phase == PH_RETURNING) && !stall && !pc_next_sel;
  endfunction

  task automatic model_step();
    bit accepted, found, np[NUM];
    int winner;
    if (rst) begin model_reset(); return; end
    accepted = m_override();
    found = 0; winner = 0;
    if (m_gie && m_phase == PH_WAIT)
      for (int i = 0; i < NUM; i++)
        if (!found && m_pend[i] && m_mask[i]) begin found = 1; winner = i; end
    for (int i = 0; i < NUM; i++) np[i] = m_pend[i];
    if (found) np[winner] = 0;
    if (cfg_we && cfg_addr == 2'd2)
      for (int i = 0; i < NUM; i++) if (cfg_wdata[i]) np[i] = 0;
    for (int i = 0; i < NUM; i++) begin
      if (irq_in[i] && !m_prev[i]) np[i] = 1;
      m_prev[i] = irq_in[i];
      m_pend[i] = np[i];
    end
    if (cfg_we && cfg_addr == 2'd0) for (int i = 0; i < NUM; i++) m_mask[i] = cfg_wdata[i];
    if (cfg_we && cfg_addr == 2'd1) m_gie = cfg_wdata[0];
    case (m_phase)
      PH_WAIT: if (found) begin
        m_id = winner; m_addr = VB + VS * 32'(winner); m_phase = PH_TAKING;
      end
      PH_TAKING: if (accepted) begin
        m_epc = fetch_pc + 32'd4; m_isr = 1; m_phase = PH_HANDLER;
      end
      PH_HANDLER: if (mret) begin m_addr = m_epc; m_phase = PH_RETURNING; end
      default: if (accepted) begin m_isr = 0; m_phase = PH_WAIT; end
    endcase
  endtask

  // Called at posedge+1 after inputs are set: predict this cycle, then advance one edge.
  task automatic step();
    exp_t e;
    if (rst) model_reset();
    e.en = m_override() && !rst;
    e.addr = m_addr; e.id = 3'(m_id); e.isr = m_isr; e.rdata = m_read(cfg_addr);
    sb_q.push_back(e);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    stall = 0; pc_next_sel = 0; mret = 0; cfg_we = 0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 0;
  endtask

  task automatic do_mret();
    mret = 1; step(); mret = 0;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("interrupt_en", 32'(interrupt_en), 32'(e.en));
      chk("in_isr", 32'(in_isr), 32'(e.isr));
      chk("irq_id", 32'(irq_id), 32'(e.id));
      chk("handler_addr", interrupt_handling_addr, e.addr);
      chk("cfg_rdata", cfg_rdata, e.rdata);
    end
  end

  initial begin
    model_reset();
    @(posedge clk); #1;
    step(); step();
    rst = 0;
    step();

    // Basic take of source 2.
    cfg_write(2'd0, 32'hF);
    cfg_write(2'd1, 32'h1);
    irq_in = 4'b0100; fetch_pc = 32'h40; cfg_addr = 2'd3;
    step(); step();
    chk("s1_vec", interrupt_handling_addr, 32'h120);
    chk("s1_id", 32'(irq_id), 32'd2);
    step();
    chk("s1_in_isr", 32'(in_isr), 32'd1);
    chk("s1_epc", cfg_rdata, 32'h44);
    fetch_pc = 32'h120; irq_in = 4'b0000;
    step(); do_mret();
    chk("s1_ret_addr", interrupt_handling_addr, 32'h44);
    step();
    chk("s1_isr_clear", 32'(in_isr), 32'd0);

    // Simultaneous sources 1 and 3.
    irq_in = 4'b1010;
    step(); step();
    chk("s2_first_vec", interrupt_handling_addr, 32'h110);
    step(); do_mret(); step(); step();
    chk("s2_second_vec", interrupt_handling_addr, 32'h130);
    chk("s2_second_id", 32'(irq_id), 32'd3);
    step(); do_mret(); step();
    cfg_addr = 2'd2; step();
    chk("s2_pending_empty", cfg_rdata, 32'h0);
    irq_in = 4'b0000; step();

    // Take blocked by stall then redirect.
    irq_in = 4'b0001; stall = 1; cfg_addr = 2'd3; fetch_pc = 32'h180;
    step(); step();
    for (int i = 0; i < 3; i++) step();
    stall = 0; pc_next_sel = 1; step();
    pc_next_sel = 0; fetch_pc = 32'h200; step();
    chk("s3_in_isr", 32'(in_isr), 32'd1);
    chk("s3_epc", cfg_rdata, 32'h204);
    do_mret(); step();
    irq_in = 4'b0000; step();

    // Request arriving inside the handler waits for the return.
    irq_in = 4'b0100; step(); step(); step();
    irq_in = 4'b0101; step();
    irq_in = 4'b0100; cfg_addr = 2'd2; step();
    chk("s4_pend_in_isr", cfg_rdata, 32'h1);
    chk("s4_no_nest", 32'(irq_id), 32'd2);
    do_mret(); step(); step();
    chk("s4_vec0", interrupt_handling_addr, 32'h100);
    step(); do_mret(); step();
    irq_in = 4'b0000; step();

    // gie off, write-1-to-clear, and set-beats-clear.
    cfg_write(2'd1, 32'h0);
    irq_in = 4'b0010; step(); step(); step();
    cfg_addr = 2'd2; step();
    chk("s5_no_take", 32'(in_isr), 32'd0);
    chk("s5_pending", cfg_rdata, 32'h2);
    cfg_write(2'd2, 32'h2);
    chk("s5_cleared", cfg_rdata, 32'h0);
    irq_in = 4'b0000; step();
    irq_in = 4'b0010; cfg_write(2'd2, 32'h2);
    chk("s5_set_wins", cfg_rdata, 32'h2);

    // Reset while a take is stalled.
    stall = 1; cfg_write(2'd1, 32'h1);
    step(); step();
    rst = 1; #1;
    chk("s6_en_in_reset", 32'(interrupt_en), 32'd0);
    step();
    rst = 0; quiet(); irq_in = 4'b0000;
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a); #1;
      chk("s6_reg_zero", cfg_rdata, 32'h0);
      step();
    end
    cfg_write(2'd0, 32'hF);
    cfg_write(2'd1, 32'h1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 3) == 0) irq_in = NUM'($urandom_range(0, 15));
      stall       = ($urandom_range(0, 3) == 0);
      pc_next_sel = ($urandom_range(0, 5) == 0);
      mret        = ($urandom_range(0, 7) == 0);
      cfg_we      = ($urandom_range(0, 11) == 0);
      cfg_addr    = 2'($urandom_range(0, 3));
      cfg_wdata   = $urandom;
      if (cfg_addr == 2'd1) cfg_wdata[0] = ($urandom_range(0, 3) != 0);
      fetch_pc    = $urandom & 32'hFFFF_FFFC;
      step();
    end

    rst = 0; quiet();
    step(); step();
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
